// File: rtl/_piso_serializer_pkg.sv
// ============================================================================
// Module   : _piso_serializer_pkg
// Brief    : Shared state encoding for the PISO serializer controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package _piso_serializer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_SHIFT = 2'b01;
  localparam state_t ST_DONE  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/_piso_serializer_if.sv
// ============================================================================
// Module   : _piso_serializer_if
// Brief    : Load handshake, bit-rate enable and serial output bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface _piso_serializer_if #(
  parameter int WIDTH = 8
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] d_in;
  logic             shift_en;
  logic             s_out;
  logic             s_valid;
  logic             done;

  modport master (
    output load_valid, d_in, shift_en,
    input  load_ready, s_out, s_valid, done
  );

  modport slave (
    input  load_valid, d_in, shift_en,
    output load_ready, s_out, s_valid, done
  );

endinterface

`default_nettype wire

// File: rtl/_dff_r_sync_en.sv
// ============================================================================
// Module   : _dff_r_sync_en
// Brief    : 1-bit DFF, synchronous active-high reset, enable, 2:1 D mux.
// Revision : 1.0
// ============================================================================
`default_nettype none

module _dff_r_sync_en (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_en,
  input  wire logic i_sel,
  input  wire logic i_d0,
  input  wire logic i_d1,
  output logic      o_q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= 1'b0;
    end else if (i_en) begin
      r_q <= i_sel ? i_d1 : i_d0;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/_piso_serializer.sv
// ============================================================================
// Module   : _piso_serializer
// Brief    : Parallel-in/serial-out stage; PISO_LSB_FIRST_EN selects LSB-first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module _piso_serializer #(
  parameter int WIDTH = 8
) (
  input  wire logic          clk,
  input  wire logic          reset,
  _piso_serializer_if.slave  bus
);

  import _piso_serializer_pkg::*;

  localparam int            CNT_W      = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_sr;
  logic [WIDTH-1:0] w_shift_in;
  logic             w_out_bit;
  logic             w_accept;
  logic             w_last;
  logic             w_advance;
  logic             w_sr_en;
  logic             w_load_ready;
  logic             w_s_valid;
  logic             w_s_out;
  logic             w_done;

  assign w_accept  = (r_state == ST_IDLE) && bus.load_valid;
  assign w_last    = (r_cnt == '0);
  assign w_advance = (r_state == ST_SHIFT) && bus.shift_en && !w_last;
  assign w_sr_en   = w_accept || w_advance;

`ifdef PISO_LSB_FIRST_EN
  assign w_shift_in = {1'b0, w_sr[WIDTH-1:1]};
  assign w_out_bit  = w_sr[0];
`else
  assign w_shift_in = {w_sr[WIDTH-2:0], 1'b0};
  assign w_out_bit  = w_sr[WIDTH-1];
`endif

  // Each stage loads its d_in bit on accept, otherwise takes its neighbour.
  for (genvar i = 0; i < WIDTH; i++) begin : g_sr_bit
    _dff_r_sync_en u_dff (
      .clk   (clk),
      .rst   (reset),
      .i_en  (w_sr_en),
      .i_sel (w_accept),
      .i_d0  (w_shift_in[i]),
      .i_d1  (bus.d_in[i]),
      .o_q   (w_sr[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (bus.shift_en && w_last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode registered state only, so no input-to-output path exists.
  always_comb begin
    w_load_ready = 1'b0;
    w_s_valid    = 1'b0;
    w_s_out      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE:  w_load_ready = 1'b1;
      ST_SHIFT: begin
        w_s_valid = 1'b1;
        w_s_out   = w_out_bit;
      end
      ST_DONE:  w_done = 1'b1;
      default:  w_load_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= C_CNT_INIT;
    end else if (w_advance) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign bus.load_ready = w_load_ready;
  assign bus.s_valid    = w_s_valid;
  assign bus.s_out      = w_s_out;
  assign bus.done       = w_done;

endmodule

`default_nettype wire

// File: tb/tb__piso_serializer.sv
// ============================================================================
// Module   : tb__piso_serializer
// Brief    : Vector table, directed corner cases and random run vs bit-queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb__piso_serializer;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  _piso_serializer_if #(.WIDTH(WIDTH)) bus ();

  _piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic       lv;
    logic [7:0] d;
    logic       se;
    logic       e_rdy;
    logic       e_vld;
    logic       e_sout;
    logic       e_done;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference: a queue of bits still to be sent, plus a pending done flag.
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  bit m_q[$];

  function automatic bit m_ready();
    return !m_busy && !m_done;
  endfunction

  function automatic bit m_sout();
    return m_busy ? m_q[0] : 1'b0;
  endfunction

  function automatic void model_edge(logic rst, logic lv, logic [7:0] d, logic se);
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_q.delete();
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy) begin
      if (se) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (lv) begin
      m_q.delete();
`ifdef PISO_LSB_FIRST_EN
      for (int i = 0; i < WIDTH; i++) m_q.push_back(d[i]);
`else
      for (int i = WIDTH - 1; i >= 0; i--) m_q.push_back(d[i]);
`endif
      m_busy = 1'b1;
    end
  endfunction

  function automatic logic [7:0] collect(logic [7:0] w, logic b);
`ifdef PISO_LSB_FIRST_EN
    return {b, w[7:1]};
`else
    return {w[6:0], b};
`endif
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    cmp({tag, ".load_ready"}, 32'(bus.load_ready), 32'(m_ready()));
    cmp({tag, ".s_valid"},    32'(bus.s_valid),    32'(m_busy));
    cmp({tag, ".s_out"},      32'(bus.s_out),      32'(m_sout()));
    cmp({tag, ".done"},       32'(bus.done),       32'(m_done));
  endtask

  task automatic do_edge(input logic rst, input logic lv, input logic [7:0] d, input logic se);
    reset          = rst;
    bus.load_valid = lv;
    bus.d_in       = d;
    bus.shift_en   = se;
    @(posedge clk);
    model_edge(rst, lv, d, se);
  endtask

  vec_t tbl [11];

  initial begin : main
    logic [7:0] w;
    logic       se;
    logic       lv;
    int         n_done;
    int         n_acc;
    int         t_acc [2];

`ifdef PISO_LSB_FIRST_EN
    tbl[0] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 8'h34, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 8'h56, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 8'h78, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 8'h9A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    tbl[0] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 8'h34, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 8'h56, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 8'h78, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 8'h9A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
`endif
    tbl[9]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset held two cycles with a load offered; nothing may be accepted.
    reset = 1'b1; bus.load_valid = 1'b1; bus.d_in = 8'hAA; bus.shift_en = 1'b1;
    @(negedge clk);
    do_edge(1'b1, 1'b1, 8'hAA, 1'b1);
    @(negedge clk);
    do_edge(1'b1, 1'b1, 8'hAA, 1'b1);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      cmp($sformatf("tbl%0d.load_ready", i), 32'(bus.load_ready), 32'(tbl[i].e_rdy));
      cmp($sformatf("tbl%0d.s_valid", i),    32'(bus.s_valid),    32'(tbl[i].e_vld));
      cmp($sformatf("tbl%0d.s_out", i),      32'(bus.s_out),      32'(tbl[i].e_sout));
      cmp($sformatf("tbl%0d.done", i),       32'(bus.done),       32'(tbl[i].e_done));
      do_edge(tbl[i].rst, tbl[i].lv, tbl[i].d, tbl[i].se);
    end

    // Stalled shift: shift_en toggles, every bit held two cycles.
    @(negedge clk); check_model("stall_ld");
    do_edge(1'b0, 1'b1, 8'hC3, 1'b0);
    w = '0; n_done = 0;
    for (int c = 0; c < 20; c++) begin
      se = c[0] ? 1'b0 : 1'b1;
      @(negedge clk); check_model("stall");
      if (bus.s_valid && se) w = collect(w, bus.s_out);
      if (bus.done) n_done++;
      do_edge(1'b0, 1'b0, 8'(c), se);
    end
    cmp("stall.word", 32'(w), 32'h0000_00C3);
    cmp("stall.done_count", 32'(n_done), 32'd1);

    // Back-to-back with load_valid held high; d_in scrambled while busy.
    n_acc = 0; t_acc[0] = -1; t_acc[1] = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk); check_model("b2b");
      if (bus.load_ready && n_acc < 2) begin
        t_acc[n_acc] = c;
        n_acc++;
      end
      lv = 1'b1;
      if (!m_ready()) do_edge(1'b0, lv, 8'($urandom), 1'b1);
      else if (t_acc[0] == c) do_edge(1'b0, lv, 8'hFF, 1'b1);
      else do_edge(1'b0, lv, 8'h00, 1'b1);
    end
    cmp("b2b.spacing", 32'(t_acc[1] - t_acc[0]), 32'(WIDTH + 2));

    // Reset after three bits aborts the word without a done pulse.
    @(negedge clk); do_edge(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk); do_edge(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk); check_model("abort_ld");
    do_edge(1'b0, 1'b1, 8'hA5, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); check_model("abort_sh");
      do_edge(1'b0, 1'b0, 8'h00, 1'b1);
    end
    @(negedge clk); do_edge(1'b1, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    cmp("abort.s_valid", 32'(bus.s_valid), 32'd0);
    cmp("abort.load_ready", 32'(bus.load_ready), 32'd1);
    cmp("abort.done", 32'(bus.done), 32'd0);
    do_edge(1'b0, 1'b1, 8'h81, 1'b1);
    w = '0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk); check_model("reload");
      if (bus.s_valid) w = collect(w, bus.s_out);
      do_edge(1'b0, 1'b0, 8'h00, 1'b1);
    end
    cmp("reload.word", 32'(w), 32'h0000_0081);

    // Randomized traffic against the bit-queue model.
    @(negedge clk); do_edge(1'b1, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk); check_model("rand");
      do_edge(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
              8'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
